burst_mem: RTL and testbench

BURST_MEM -- requirements
Module: burst_mem

---
 rtl/mem_pkg.sv | 19 +
 rtl/burst_mem_if.sv | 36 +++
 rtl/lat_counter.sv | 27 ++
 rtl/burst_mem.sv | 138 +++++++++++++
 tb/tb_burst_mem.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and width helper for the burst memory block.
package mem_pkg;

  localparam int unsigned LEN_ADR_DEF  = 16;
  localparam int unsigned LEN_DATA_DEF = 32;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/burst_mem_if.sv
// Request/response bus of burst_mem. The err signal exists only when
// MEM_RANGE_CHECK_EN is defined.
interface burst_mem_if #(
  parameter int unsigned LEN_ADR  = mem_pkg::LEN_ADR_DEF,
  parameter int unsigned LEN_DATA = mem_pkg::LEN_DATA_DEF,
  parameter int unsigned WPB      = 4
);

  logic                    read;
  logic                    write;
  logic [LEN_ADR-1:0]      adr;
  logic [LEN_DATA-1:0]     data;
  logic                    ready;
  logic                    busy;
  logic [LEN_DATA*WPB-1:0] out;
`ifdef MEM_RANGE_CHECK_EN
  logic                    err;
`endif

  modport master (
    output read, write, adr, data,
`ifdef MEM_RANGE_CHECK_EN
    input  err,
`endif
    input  ready, busy, out
  );

  modport slave (
    input  read, write, adr, data,
`ifdef MEM_RANGE_CHECK_EN
    output err,
`endif
    output ready, busy, out
  );

endinterface

// File: rtl/lat_counter.sv
// Down-counter for request latency: parallel load, decrement to zero, zero flag.
module lat_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/burst_mem.sv
// Fixed-latency word-write / block-read memory. Defining MEM_RANGE_CHECK_EN
// adds an err output and suppresses out-of-range accesses instead of wrapping.
module burst_mem
  import mem_pkg::*;
#(
  parameter int unsigned LEN_ADR  = LEN_ADR_DEF,
  parameter int unsigned LEN_DATA = LEN_DATA_DEF,
  parameter int unsigned DEPTH    = 2048,
  parameter int unsigned WPB      = 4,
  parameter int unsigned LATENCY  = 4
) (
  input logic       clk,
  input logic       rst,
  burst_mem_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? log2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? log2(LATENCY) : 1;

  state_e state_q, state_d;
  logic   accept, fire, cnt_zero, range_err;

  logic [LEN_ADR-1:0]      adr_q, base;
  logic [LEN_DATA-1:0]     data_q;
  logic                    op_rd_q;
  logic                    ready_q, busy_q;
  logic [LEN_DATA*WPB-1:0] out_q;
  logic [LEN_DATA-1:0]     mem_q [DEPTH];

  // Address arithmetic wraps modulo DEPTH.
  function automatic logic [AW-1:0] word_idx(input logic [LEN_ADR-1:0] a, input int unsigned i);
    int unsigned s;
    s = (32'(a) + i) % DEPTH;
    return AW'(s);
  endfunction

  assign base = adr_q & ~(LEN_ADR'(WPB - 1));

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;
  assign range_err = op_rd_q ? ((32'(base) + WPB) > DEPTH) : (32'(adr_q) >= DEPTH);
`else
  assign range_err = 1'b0;
`endif

  lat_counter #(
    .Width (CW)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .dec_i  (state_q == StWait),
    .val_i  (CW'(LATENCY - 1)),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.read || bus.write) begin
          accept  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          fire    = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields are only meaningful while an op is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q   <= bus.adr;
      data_q  <= bus.data;
      op_rd_q <= bus.read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      ready_q <= fire;
      if (accept) begin
        busy_q <= 1'b1;
      end else if (fire) begin
        busy_q <= 1'b0;
      end
      if (fire && op_rd_q && !range_err) begin
        for (int i = 0; i < WPB; i++) begin
          out_q[i*LEN_DATA +: LEN_DATA] <= mem_q[word_idx(base, i)];
        end
      end
    end
  end

  // Storage survives reset; a reset landing on the completion edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && fire && !op_rd_q && !range_err) begin
      mem_q[word_idx(adr_q, 0)] <= data_q;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire && range_err;
    end
  end
  assign bus.err = err_q;
`endif

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.out   = out_q;

endmodule

// File: tb/tb_burst_mem.sv
// Directed plus randomized bench for burst_mem against an array-based reference model.
module tb_burst_mem;

  localparam int unsigned LEN_ADR  = 16;
  localparam int unsigned LEN_DATA = 32;
  localparam int unsigned DEPTH    = 2048;
  localparam int unsigned WPB      = 4;
  localparam int unsigned LATENCY  = 4;
  localparam int unsigned OW       = LEN_DATA * WPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_mem_if #(.LEN_ADR(LEN_ADR), .LEN_DATA(LEN_DATA), .WPB(WPB)) bus ();

  burst_mem #(
    .LEN_ADR  (LEN_ADR),
    .LEN_DATA (LEN_DATA),
    .DEPTH    (DEPTH),
    .WPB      (WPB),
    .LATENCY  (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [LEN_DATA-1:0] mdl [DEPTH];
  logic [OW-1:0]       exp_out;
  logic                exp_err;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic out_of_range(input logic rd, input int unsigned a);
    int unsigned b;
    b = a & ~(WPB - 1);
    return rd ? ((b + WPB) > DEPTH) : (a >= DEPTH);
  endfunction

  // Reference behaviour: read wins, block base aligned down, addresses wrap or fault.
  task automatic model(input logic rd, input logic wr, input int unsigned a,
                       input logic [LEN_DATA-1:0] d);
    int unsigned b;
`ifdef MEM_RANGE_CHECK_EN
    exp_err = out_of_range(rd, a);
`else
    exp_err = 1'b0;
`endif
    if (!exp_err) begin
      if (rd) begin
        b = a & ~(WPB - 1);
        for (int i = 0; i < WPB; i++) exp_out[i*LEN_DATA +: LEN_DATA] = mdl[(b + i) % DEPTH];
      end else if (wr) begin
        mdl[a % DEPTH] = d;
      end
    end
  endtask

  // One request; glitch drops read after accept and pulses it again while busy.
  task automatic run(input logic rd, input logic wr, input int unsigned a,
                     input logic [LEN_DATA-1:0] d, input bit glitch, input string tag);
    logic [15:0] rt, bt, et, er, eb;
    rt = '0; bt = '0; et = '0;
    er = 16'(1) << LATENCY;
    eb = (16'(1) << LATENCY) - 16'(1);
    @(negedge clk);
    bus.read  = rd;
    bus.write = wr;
    bus.adr   = a[LEN_ADR-1:0];
    bus.data  = d;
    for (int n = 0; n <= LATENCY + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      rt[n] = bus.ready;
      bt[n] = bus.busy;
`ifdef MEM_RANGE_CHECK_EN
      et[n] = bus.err;
`endif
      if (glitch) begin
        if (n == 0) bus.read = 1'b0;
        else if (n == 1) begin
          bus.read = 1'b1;
          bus.adr  = 16'd32;
        end else if (n == 2) bus.read = 1'b0;
      end
      if (bus.ready) begin
        bus.read  = 1'b0;
        bus.write = 1'b0;
      end
    end
    model(rd, wr, a, d);
    check({tag, " ready"}, OW'(rt), OW'(er));
    check({tag, " busy"}, OW'(bt), OW'(eb));
    check({tag, " out"}, bus.out, exp_out);
`ifdef MEM_RANGE_CHECK_EN
    check({tag, " err"}, OW'(et), exp_err ? OW'(er) : OW'(0));
`else
    if (et != 16'd0) check({tag, " err"}, OW'(et), OW'(0));
`endif
  endtask

  initial begin
    int unsigned a, rcount;
    logic rd, wr;

    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.adr = '0; bus.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_out = '0;
    exp_err = 1'b0;
    check("reset ready", OW'(bus.ready), OW'(0));
    check("reset busy", OW'(bus.busy), OW'(0));
    check("reset out", bus.out, OW'(0));
`ifdef MEM_RANGE_CHECK_EN
    check("reset err", OW'(bus.err), OW'(0));
`endif

    run(1'b0, 1'b1, 1050, 32'hDEADBEEF, 1'b0, "wr1050");

    // Known contents for every address the rest of the bench reads.
    for (int i = 0; i < 64; i++) run(1'b0, 1'b1, i, $urandom, 1'b0, "fill_lo");
    for (int i = 1024; i < 1088; i++) run(1'b0, 1'b1, i, $urandom, 1'b0, "fill_hi");

    for (int i = 0; i < 4; i++) run(1'b0, 1'b1, 1048 + i, LEN_DATA'(i + 1), 1'b0, "wr_seq");
    run(1'b1, 1'b0, 1050, 32'h0, 1'b0, "rd1050");
    check("rd1050 words", bus.out, {32'd4, 32'd3, 32'd2, 32'd1});

    run(1'b1, 1'b1, 8, 32'h12345678, 1'b0, "rdwr8");
    run(1'b1, 1'b0, 8, 32'h0, 1'b0, "rd8_after");

    run(1'b1, 1'b0, 16, 32'h0, 1'b1, "rd_busy_glitch");

    // Reset two cycles into a write must abort it silently.
    @(negedge clk);
    bus.write = 1'b1; bus.adr = 16'd5; bus.data = 32'hBAD0BAD0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    bus.write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_out = '0;
    rcount = 0;
    for (int n = 0; n < LATENCY + 4; n++) begin
      rcount += 32'(bus.ready);
      @(posedge clk);
      @(negedge clk);
    end
    check("abort ready count", OW'(rcount), OW'(0));
    check("abort busy", OW'(bus.busy), OW'(0));
    check("abort out", bus.out, OW'(0));
    run(1'b1, 1'b0, 5, 32'h0, 1'b0, "rd5_after_abort");

    run(1'b1, 1'b0, 4096, 32'h0, 1'b0, "rd4096");
`ifndef MEM_RANGE_CHECK_EN
    check("rd4096 block0", bus.out, {mdl[3], mdl[2], mdl[1], mdl[0]});
`endif

    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 63) : $urandom_range(1024, 1087);
      if ($urandom_range(0, 3) == 0) a = a + DEPTH * $urandom_range(1, 31);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run(rd, wr, a, $urandom, 1'b0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
